// File: rtl/prim_secded_inv_39_32_err_mon.sv
// Consumer stage behind the inverted 39/32 SECDED decoder.
// Forwards decoded words through a 2-entry skid buffer. Classifies each
// accepted word, keeps saturating error counters, holds the first error's
// syndrome, and pulses an alert for uncorrectable words.
module prim_secded_inv_39_32_err_mon #(
  parameter int CntW        = 8,
  parameter bit ScrubUncorr = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     in_data_i,
  input  logic [6:0]      in_syndrome_i,
  input  logic [1:0]      in_err_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     out_data_o,
  output logic [1:0]      out_err_o,
  output logic [CntW-1:0] corr_cnt_o,
  output logic [CntW-1:0] uncorr_cnt_o,
  output logic            first_err_vld_o,
  output logic [6:0]      first_syndrome_o,
  output logic [1:0]      first_err_type_o,
  output logic            alert_o
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  logic [31:0]     out_data_q, skid_data_q;
  logic [1:0]      out_err_q, skid_err_q;
  logic            load_out, load_skid, move_skid;
  logic            accept, take;
  logic [1:0]      cls;
  logic [31:0]     word_data;
  logic [CntW-1:0] corr_q, corr_d, corr_base;
  logic [CntW-1:0] uncorr_q, uncorr_d, uncorr_base;
  logic            fe_vld_q, fe_vld_d, fe_vld_base;
  logic [6:0]      fe_syn_q, fe_syn_d;
  logic [1:0]      fe_type_q, fe_type_d;
  logic            alert_q, alert_d;

  assign accept = in_valid_i && in_ready_q;
  assign take   = out_valid_o && out_ready_i;

  // Error class: the uncorrectable flag dominates, so the illegal 2'b11 folds into it.
  assign cls       = in_err_i[1] ? 2'b10 : (in_err_i[0] ? 2'b01 : 2'b00);
  assign word_data = (ScrubUncorr && cls == 2'b10) ? 32'h0 : in_data_i;

  // Buffer next-state and datapath steering.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = StOne;
        end
      end
      StOne: begin
        if (accept && take) begin
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = StFull;
        end else if (take) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (take) begin
          move_skid = 1'b1;
          state_d   = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Ready is registered from the next state, so out_ready_i never reaches in_ready_o combinationally.
    in_ready_d = (state_d != StFull);
  end

  // Buffer state, ready register and word storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_data_q  <= 32'h0;
      out_err_q   <= 2'b00;
      skid_data_q <= 32'h0;
      skid_err_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      if (load_out) begin
        out_data_q <= word_data;
        out_err_q  <= cls;
      end else if (move_skid) begin
        out_data_q <= skid_data_q;
        out_err_q  <= skid_err_q;
      end
      if (load_skid) begin
        skid_data_q <= word_data;
        skid_err_q  <= cls;
      end
    end
  end

  // Counters and capture: a same-cycle clear is applied before the new error.
  always_comb begin
    corr_base   = clr_i ? '0 : corr_q;
    uncorr_base = clr_i ? '0 : uncorr_q;
    fe_vld_base = clr_i ? 1'b0 : fe_vld_q;
    corr_d      = corr_base;
    uncorr_d    = uncorr_base;
    fe_vld_d    = fe_vld_base;
    fe_syn_d    = clr_i ? 7'h0 : fe_syn_q;
    fe_type_d   = clr_i ? 2'b00 : fe_type_q;
    alert_d     = accept && (cls == 2'b10);
    if (accept && cls == 2'b01 && corr_base != '1) begin
      corr_d = corr_base + CntW'(1);
    end
    if (accept && cls == 2'b10 && uncorr_base != '1) begin
      uncorr_d = uncorr_base + CntW'(1);
    end
    if (accept && cls != 2'b00 && !fe_vld_base) begin
      fe_vld_d  = 1'b1;
      fe_syn_d  = in_syndrome_i;
      fe_type_d = cls;
    end
  end

  // Error monitor registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      corr_q    <= '0;
      uncorr_q  <= '0;
      fe_vld_q  <= 1'b0;
      fe_syn_q  <= 7'h0;
      fe_type_q <= 2'b00;
      alert_q   <= 1'b0;
    end else begin
      corr_q    <= corr_d;
      uncorr_q  <= uncorr_d;
      fe_vld_q  <= fe_vld_d;
      fe_syn_q  <= fe_syn_d;
      fe_type_q <= fe_type_d;
      alert_q   <= alert_d;
    end
  end

  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = (state_q != StEmpty);
  assign out_data_o       = out_data_q;
  assign out_err_o        = out_err_q;
  assign corr_cnt_o       = corr_q;
  assign uncorr_cnt_o     = uncorr_q;
  assign first_err_vld_o  = fe_vld_q;
  assign first_syndrome_o = fe_syn_q;
  assign first_err_type_o = fe_type_q;
  assign alert_o          = alert_q;

endmodule

// File: tb/tb_prim_secded_inv_39_32_err_mon.sv
// Bench for prim_secded_inv_39_32_err_mon: two instances share stimulus
// (CntW=2 with scrubbing, CntW=8 without). A scoreboard queue tracks the
// words in flight; a per-cycle model tracks counters, capture and alert.
module tb_prim_secded_inv_39_32_err_mon;

  logic        clk = 1'b0;
  logic        rst_i, clr_i, in_valid_i, out_ready_i;
  logic [31:0] in_data_i;
  logic [6:0]  in_syndrome_i;
  logic [1:0]  in_err_i;

  logic        a_in_ready, a_out_valid, a_fe_vld, a_alert;
  logic [31:0] a_out_data;
  logic [1:0]  a_out_err, a_fe_type;
  logic [1:0]  a_corr, a_uncorr;
  logic [6:0]  a_fe_syn;

  logic        b_in_ready, b_out_valid, b_fe_vld, b_alert;
  logic [31:0] b_out_data;
  logic [1:0]  b_out_err, b_fe_type;
  logic [7:0]  b_corr, b_uncorr;
  logic [6:0]  b_fe_syn;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data_scrub;
    logic [31:0] data_raw;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];

  // model state
  logic [1:0] m_corr2, m_uncorr2;
  logic [7:0] m_corr8, m_uncorr8;
  logic       m_fe_vld, m_alert;
  logic [6:0] m_fe_syn;
  logic [1:0] m_fe_type;
  bit         last_acc;

  always #5 clk = ~clk;

  prim_secded_inv_39_32_err_mon #(.CntW(2), .ScrubUncorr(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .in_valid_i(in_valid_i), .in_ready_o(a_in_ready),
    .in_data_i(in_data_i), .in_syndrome_i(in_syndrome_i), .in_err_i(in_err_i),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(a_out_data), .out_err_o(a_out_err),
    .corr_cnt_o(a_corr), .uncorr_cnt_o(a_uncorr),
    .first_err_vld_o(a_fe_vld), .first_syndrome_o(a_fe_syn),
    .first_err_type_o(a_fe_type), .alert_o(a_alert)
  );

  prim_secded_inv_39_32_err_mon #(.CntW(8), .ScrubUncorr(1'b0)) dut_ns (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .in_valid_i(in_valid_i), .in_ready_o(b_in_ready),
    .in_data_i(in_data_i), .in_syndrome_i(in_syndrome_i), .in_err_i(in_err_i),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready_i),
    .out_data_o(b_out_data), .out_err_o(b_out_err),
    .corr_cnt_o(b_corr), .uncorr_cnt_o(b_uncorr),
    .first_err_vld_o(b_fe_vld), .first_syndrome_o(b_fe_syn),
    .first_err_type_o(b_fe_type), .alert_o(b_alert)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_corr2 = '0; m_uncorr2 = '0; m_corr8 = '0; m_uncorr8 = '0;
    m_fe_vld = 1'b0; m_fe_syn = '0; m_fe_type = '0; m_alert = 1'b0;
    last_acc = 1'b0;
    sb.delete();
  endtask

  // Per-cycle model: compare current DUT state, then advance the model to the next edge.
  always @(negedge clk) begin
    bit         exp_ready, exp_valid, acc;
    logic [1:0] cls;
    exp_t       e;
    if (rst_i) begin
      model_reset();
    end else begin
      exp_ready = (sb.size() < 2);
      exp_valid = (sb.size() > 0);
      check_eq("in_ready",   a_in_ready,  exp_ready);
      check_eq("out_valid",  a_out_valid, exp_valid);
      check_eq("ns_in_ready",  b_in_ready,  exp_ready);
      check_eq("ns_out_valid", b_out_valid, exp_valid);
      check_eq("corr_cnt",   a_corr,    m_corr2);
      check_eq("uncorr_cnt", a_uncorr,  m_uncorr2);
      check_eq("ns_corr_cnt",   b_corr,   m_corr8);
      check_eq("ns_uncorr_cnt", b_uncorr, m_uncorr8);
      check_eq("fe_vld",  a_fe_vld,  m_fe_vld);
      check_eq("fe_syn",  a_fe_syn,  m_fe_syn);
      check_eq("fe_type", a_fe_type, m_fe_type);
      check_eq("ns_fe_syn", b_fe_syn, m_fe_syn);
      check_eq("alert",    a_alert, m_alert);
      check_eq("ns_alert", b_alert, m_alert);
      if (a_out_valid && out_ready_i) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check_eq("out_data",    a_out_data, e.data_scrub);
          check_eq("out_err",     a_out_err,  e.err);
          check_eq("ns_out_data", b_out_data, e.data_raw);
          check_eq("ns_out_err",  b_out_err,  e.err);
          $display("out: data=%h err=%b ns_data=%h", a_out_data, a_out_err, b_out_data);
        end
      end
      acc      = in_valid_i && exp_ready;
      last_acc = acc;
      cls      = in_err_i[1] ? 2'b10 : (in_err_i[0] ? 2'b01 : 2'b00);
      if (clr_i) begin
        m_corr2 = '0; m_uncorr2 = '0; m_corr8 = '0; m_uncorr8 = '0;
        m_fe_vld = 1'b0; m_fe_syn = '0; m_fe_type = '0;
      end
      if (acc) begin
        e.data_scrub = (cls == 2'b10) ? 32'h0 : in_data_i;
        e.data_raw   = in_data_i;
        e.err        = cls;
        sb.push_back(e);
        $display("in:  data=%h syn=%h err=%b clr=%b", in_data_i, in_syndrome_i, in_err_i, clr_i);
        if (cls == 2'b01) begin
          if (m_corr2 != 2'd3)   m_corr2 = m_corr2 + 2'd1;
          if (m_corr8 != 8'hFF)  m_corr8 = m_corr8 + 8'd1;
        end
        if (cls == 2'b10) begin
          if (m_uncorr2 != 2'd3)  m_uncorr2 = m_uncorr2 + 2'd1;
          if (m_uncorr8 != 8'hFF) m_uncorr8 = m_uncorr8 + 8'd1;
        end
        if (cls != 2'b00 && !m_fe_vld) begin
          m_fe_vld = 1'b1; m_fe_syn = in_syndrome_i; m_fe_type = cls;
        end
      end
      m_alert = acc && (cls == 2'b10);
    end
  end

  // Offer one word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] d, input logic [6:0] syn, input logic [1:0] err, input logic clr);
    bit done = 1'b0;
    in_valid_i = 1'b1; in_data_i = d; in_syndrome_i = syn; in_err_i = err; clr_i = clr;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      done = last_acc;
    end
    #1;
    if (!done) check_eq("accept_timeout", 0, 1);
    in_valid_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; clr_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    in_data_i = '0; in_syndrome_i = '0; in_err_i = '0;
    model_reset();
    idle(2);
    check_eq("rst_in_ready",  a_in_ready, 1);
    check_eq("rst_out_valid", a_out_valid, 0);
    rst_i = 1'b0;
    idle(2);

    // clean, correctable, uncorrectable
    send(32'hDEADBEEF, 7'h00, 2'b00, 1'b0);
    idle(2);
    send(32'h00000001, 7'h19, 2'b01, 1'b0);
    idle(2);
    check_eq("tp_fe_syn", a_fe_syn, 7'h19);
    send(32'h12345678, 7'h03, 2'b10, 1'b0);
    idle(3);
    // back-to-back uncorrectable, including the illegal 2'b11 code
    send(32'hCAFEF00D, 7'h11, 2'b10, 1'b0);
    send(32'hA5A5A5A5, 7'h22, 2'b11, 1'b0);
    idle(3);

    // backpressure: A, B fill the buffer, C waits until release
    out_ready_i = 1'b0;
    send(32'hAAAA0001, 7'h00, 2'b00, 1'b0);
    send(32'hBBBB0002, 7'h05, 2'b01, 1'b0);
    check_eq("bp_ready_low", a_in_ready, 0);
    fork
      send(32'hCCCC0003, 7'h00, 2'b00, 1'b0);
      begin
        idle(3);
        check_eq("bp_hold_data", a_out_data, 32'hAAAA0001);
        out_ready_i = 1'b1;
      end
    join
    idle(4);

    // saturation on the 2-bit counters, then clear coincident with an error
    clr_i = 1'b1;
    idle(1);
    clr_i = 1'b0;
    for (int k = 0; k < 5; k++) send(32'h100 + k, 7'h30 + 7'(k), 2'b01, 1'b0);
    check_eq("sat_corr3", a_corr, 2'd3);
    send(32'h00000600, 7'h54, 2'b01, 1'b1);
    check_eq("clr_corr1", a_corr, 2'd1);
    check_eq("clr_fe_syn", a_fe_syn, 7'h54);
    idle(3);

    // reset while FULL: everything in flight is dropped
    out_ready_i = 1'b0;
    send(32'h0D0D0001, 7'h00, 2'b00, 1'b0);
    send(32'h0D0D0002, 7'h07, 2'b10, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    check_eq("arst_out_valid", a_out_valid, 0);
    check_eq("arst_in_ready",  a_in_ready, 1);
    check_eq("arst_corr",      a_corr, 0);
    check_eq("arst_uncorr",    a_uncorr, 0);
    check_eq("arst_fe_vld",    a_fe_vld, 0);
    check_eq("arst_alert",     a_alert, 0);
    idle(2);
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    idle(4);
    send(32'h600DF00D, 7'h00, 2'b00, 1'b0);
    idle(4);
    check_eq("drain_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prim_secded_inv_39_32_err_mon.md
Name: prim_secded_inv_39_32_err_mon

Overview:
Registered consumer stage placed directly downstream of the inverted 39/32 SECDED decoder. It takes the corrected 32-bit word, 7-bit syndrome and 2-bit error flags over a valid/ready handshake and forwards the word through a 2-entry skid buffer. It also keeps saturating correctable and uncorrectable error counters, captures the first error's syndrome, and pulses an alert on uncorrectable errors. It sits between the ECC decode of a protected storage read path and the consuming logic.

Parameters:
CntW, 8, width of each saturating error counter (legal range 1..16).
ScrubUncorr, 1, when 1, the data of an uncorrectable word is replaced by 32'h0 on output; when 0, the data passes through unchanged.

Ports:
clk_i  input  1  clock; all state updates on the rising edge
rst_i  input  1  asynchronous, active-high reset
clr_i  input  1  synchronous clear of counters and first-error capture
in_valid_i  input  1  decoder result valid
in_ready_o  output  1  stage can accept a word
in_data_i  input  32  corrected data from decoder
in_syndrome_i  input  7  decoder syndrome
in_err_i  input  2  decoder error flags: bit0 = correctable (single), bit1 = uncorrectable (double)
out_valid_o  output  1  output word valid
out_ready_i  input  1  downstream accepts
out_data_o  output  32  forwarded data
out_err_o  output  2  error class travelling with the word
corr_cnt_o  output  CntW  saturating correctable-error count
uncorr_cnt_o  output  CntW  saturating uncorrectable-error count
first_err_vld_o  output  1  first-error capture holds a value
first_syndrome_o  output  7  syndrome of the first captured error
first_err_type_o  output  2  error class of the first captured error
alert_o  output  1  one-cycle pulse per accepted uncorrectable word

Behaviour:
- Reset: all outputs and state are 0, except in_ready_o, which is 1; the buffer is EMPTY. Reset is honoured mid-transfer, and in-flight words are dropped.
- Accept: a word is accepted when in_valid_i && in_ready_o. Output: a word is taken when out_valid_o && out_ready_i.
- Buffer FSM has three states:
  - EMPTY (out_valid_o=0, in_ready_o=1): on accept, go to ONE.
  - ONE (out_valid_o=1, in_ready_o=1):
    - accept and take together: stay in ONE; the output register loads the new word.
    - accept only: go to FULL; the new word goes to the skid register.
    - take only: go to EMPTY.
  - FULL (out_valid_o=1, in_ready_o=0): on take, the skid word moves to the output register and the state goes to ONE.
- in_ready_o is a register output: 1 in EMPTY and ONE, 0 in FULL. There is no combinational path from out_ready_i to in_ready_o.
- Latency: an accepted word appears on out_data_o in the next cycle when the buffer was EMPTY or ONE-with-take. Word order is preserved, with no loss and no duplication.
- out_valid_o, out_data_o and out_err_o stay stable while out_valid_o && !out_ready_i.
- Classification at accept:
  - in_err_i[1]=1 → uncorrectable (class 2'b10). in_err_i=2'b11 is illegal and is treated as uncorrectable.
  - in_err_i=2'b01 → correctable (class 2'b01).
  - in_err_i=2'b00 → clean (class 2'b00); syndrome is ignored.
- out_err_o carries the class. out_data_o is 32'h0 for uncorrectable words when ScrubUncorr=1.
- Counters increment at accept, not at output. They saturate at all-ones and never wrap.
- First-error capture:
  - On the first accepted non-clean word while first_err_vld_o=0, latch the syndrome and class and set first_err_vld_o.
  - Later errors do not overwrite the capture.
- alert_o is registered: it is 1 in the cycle after an accepted uncorrectable word and otherwise 0. Back-to-back uncorrectable words give alert_o high in consecutive cycles.
- clr_i:
  - Zeroes both counters and the first-error capture. It does not affect the buffer or alert_o.
  - If clr_i and an error accept occur in the same cycle, the clear applies first and the new error is then applied: the count becomes 1 and the capture takes the new error.

Test Plan:
- Reset, then one clean word 32'hDEADBEEF (err 00) with out_ready_i=1: out_valid_o=1 the next cycle with data DEADBEEF, err 00; counters stay 0; first_err_vld_o=0.
- Correctable word (data 32'h00000001, syndrome 7'h19, err 01): corr_cnt_o=1; first_syndrome_o=7'h19; first_err_type_o=01; alert_o stays 0.
- Uncorrectable word (syndrome 7'h03, err 10, data 32'h12345678), ScrubUncorr=1: out_data_o=0, out_err_o=10, uncorr_cnt_o=1, alert_o high for exactly one cycle. Repeat with ScrubUncorr=0: out_data_o=12345678.
- Backpressure: hold out_ready_i=0 and offer words A, B, C: A and B are accepted, in_ready_o=0 after B, C is held. Release out_ready_i: outputs are A, B, C in order with none lost.
- Saturation with CntW=2: five correctable words → corr_cnt_o=3. Then clr_i coincident with a 6th correctable word (syndrome 7'h54) → corr_cnt_o=1 and first_syndrome_o=7'h54.
- Assert rst_i while in FULL: all outputs return to reset values asynchronously, in_ready_o=1 after release, and no stale word is emitted.
